// File: rtl/sobel_axis_tx.sv
// -----------------------------------------------------------------------------
// sobel_axis_tx
//
// Egress stage of the stall-driven Sobel filter. It keeps a token line that
// shadows the filter pipeline, so it knows which pipe_data beats are real. It
// captures those beats into a first-word-fall-through skid FIFO and presents
// them as an AXI4-Stream master. tlast marks the end of an image row and tuser
// marks the first beat of a frame. It also drives the shared pipeline stall
// from a credit check, so backpressure from the sink never loses a beat.
//
// Optional feature: define SOBEL_TX_CHECK_EN to add the sticky err_ovf output.
// This flag reports FIFO or in-flight counter over/underflow. The datapath and
// cycle timing are the same whether or not the macro is defined.
//
// Ports:
//   clk            clock
//   aresetn        synchronous active-low reset
//   src_valid      upstream has a beat at the filter input this cycle
//   pipe_data      filter output beat (meaningful only when a token arrives)
//   stall          1 = freeze every filter stage and the source
//   m_axis_tdata   output beat
//   m_axis_tvalid  output beat valid
//   m_axis_tready  sink ready
//   m_axis_tlast   last beat of an image row
//   m_axis_tuser   first beat of a frame
//   err_ovf        sticky over/underflow flag (only with SOBEL_TX_CHECK_EN)
// -----------------------------------------------------------------------------
module sobel_axis_tx #(
   parameter int PIXELS_PER_BEAT = 16,
   parameter int IMAGE_DIM       = 512,
   parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
   parameter int PIPE_LATENCY    = 20,
   parameter int FIFO_DEPTH      = 32
) (
   input  logic                  clk,
   input  logic                  aresetn,
   input  logic                  src_valid,
   input  logic [DATA_WIDTH-1:0] pipe_data,
   output logic                  stall,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser
`ifdef SOBEL_TX_CHECK_EN
   ,
   output logic                  err_ovf
`endif
);

   localparam int BEATS_PER_ROW = IMAGE_DIM / PIXELS_PER_BEAT;
   localparam int CNT_W = $clog2(FIFO_DEPTH + PIPE_LATENCY + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int COL_W = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
   localparam int ROW_W = (IMAGE_DIM > 1) ? $clog2(IMAGE_DIM) : 1;

   logic [PIPE_LATENCY-1:0] tok;
   logic [PIPE_LATENCY-1:0] tok_next;
   logic                    tok_out;
   logic                    take;
   logic                    wr;
   logic                    rd;
   logic                    credit_full;
   logic [CNT_W-1:0]        inflight;
   logic [CNT_W-1:0]        fifo_count;
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
   logic [COL_W-1:0]        col;
   logic [ROW_W-1:0]        row;
   logic                    col_last;
   logic                    row_last;

   // The sum of buffered beats and beats still inside the filter is the total
   // number of beats that will eventually need FIFO space. Refusing new input
   // once that sum reaches the FIFO depth makes overflow impossible, even
   // when the sink stalls for a long time.
   assign credit_full = (fifo_count + inflight) >= CNT_W'(FIFO_DEPTH);
   assign stall       = ~src_valid | credit_full;
   assign take        = src_valid & ~stall;
   assign tok_out     = tok[PIPE_LATENCY-1];
   assign wr          = tok_out & ~stall;
   assign rd          = m_axis_tvalid & m_axis_tready;

   // The FIFO head is read straight from registered storage. A beat written at
   // cycle N is therefore visible from cycle N+1.
   assign m_axis_tvalid = (fifo_count != '0);
   assign m_axis_tdata  = mem[rd_ptr];

   // Framing flags are decoded from the counters of the head beat. They are
   // gated with tvalid so they read 0 whenever nothing is presented.
   assign col_last     = (col == COL_W'(BEATS_PER_ROW - 1));
   assign row_last     = (row == ROW_W'(IMAGE_DIM - 1));
   assign m_axis_tlast = m_axis_tvalid & col_last;
   assign m_axis_tuser = m_axis_tvalid & (col == '0) & (row == '0);

   // Next value of the token line. A new token enters at bit 0 and the oldest
   // token leaves at the top. The line only moves when the filter moves.
   always_comb begin
      tok_next    = '0;
      tok_next[0] = take;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
         tok_next[i] = tok[i-1];
      end
   end

   // FIFO storage has no reset. Only the pointers and the count decide which
   // entries are meaningful.
   always_ff @(posedge clk) begin
      if (wr) begin
         mem[wr_ptr] <= pipe_data;
      end
   end

   // Control state. The token line, the in-flight counter, the FIFO pointers
   // and count, and the framing counters are all cleared together. A reset in
   // the middle of a frame therefore drops every pending beat and restarts
   // the frame.
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         tok        <= '0;
         inflight   <= '0;
         fifo_count <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         col        <= '0;
         row        <= '0;
      end else begin
         if (!stall) begin
            tok <= tok_next;
         end

         case ({take, wr})
            2'b10:   inflight <= inflight + CNT_W'(1);
            2'b01:   inflight <= inflight - CNT_W'(1);
            default: inflight <= inflight;
         endcase

         case ({wr, rd})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase

         if (wr) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (rd) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end

         if (rd) begin
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + ROW_W'(1);
            end else begin
               col <= col + COL_W'(1);
            end
         end
      end
   end

`ifdef SOBEL_TX_CHECK_EN
   // Sticky consistency flag. The credit rule should keep all of these
   // conditions unreachable. If one ever fires, something upstream broke the
   // stall contract.
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         err_ovf <= 1'b0;
      end else if ((wr && fifo_count == CNT_W'(FIFO_DEPTH)) ||
                   (rd && fifo_count == '0) ||
                   (take && !wr && inflight == CNT_W'(PIPE_LATENCY)) ||
                   (wr && !take && inflight == '0)) begin
         err_ovf <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_sobel_axis_tx.sv
// -----------------------------------------------------------------------------
// tb_sobel_axis_tx
//
// Scoreboard bench for sobel_axis_tx. A simple delay line stands in for the
// Sobel filter and moves whenever stall is low. Every accepted input beat is
// numbered and pushed into an expected queue. Its tlast and tuser are derived
// from that beat number within the row and the frame. A monitor pops the
// queue on every output handshake and compares the beats. The monitor also
// checks the credit-based stall against the outstanding beat count. It also
// checks that the AXI output stays stable while the sink holds off.
// -----------------------------------------------------------------------------
module tb_sobel_axis_tx;

   localparam int PPB   = 16;
   localparam int DIM   = 64;
   localparam int DW    = 8 * PPB;
   localparam int LAT   = 20;
   localparam int DEPTH = 32;
   localparam int BPR   = DIM / PPB;
   localparam int FRAME = BPR * DIM;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic          user;
   } beat_t;

   logic          clk = 1'b0;
   logic          aresetn = 1'b0;
   logic          src_valid = 1'b0;
   logic [DW-1:0] src_data = '0;
   logic [DW-1:0] pipe_data;
   logic          stall;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic          m_axis_tlast;
   logic          m_axis_tuser;
`ifdef SOBEL_TX_CHECK_EN
   logic          err_ovf;
`endif

   int    checks = 0;
   int    errors = 0;
   int    beat_idx = 0;
   int    hs_count = 0;
   beat_t exp_q[$];
   logic  prev_hold = 1'b0;
   beat_t prev_beat;
   beat_t got_b;
   beat_t exp_b;
   logic  exp_stall;
   logic  [DW-1:0] pipe [LAT];

   sobel_axis_tx #(
      .PIXELS_PER_BEAT(PPB),
      .IMAGE_DIM(DIM),
      .DATA_WIDTH(DW),
      .PIPE_LATENCY(LAT),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .aresetn(aresetn),
      .src_valid(src_valid),
      .pipe_data(pipe_data),
      .stall(stall),
      .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast),
      .m_axis_tuser(m_axis_tuser)
`ifdef SOBEL_TX_CHECK_EN
      ,
      .err_ovf(err_ovf)
`endif
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Stand-in for the filter: a delay line of LAT stages that only moves when
   // stall is low, so each input beat reaches pipe_data after LAT moves.
   always @(posedge clk) begin
      if (!stall) begin
         pipe[0] <= src_data;
         for (int i = 1; i < LAT; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end
   assign pipe_data = pipe[LAT-1];

   task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Drive random inputs for n cycles. pv and pr are the percent chances
   // that src_valid and tready are high in each cycle.
   task automatic applyStimulus(input int n, input int pv, input int pr);
      repeat (n) begin
         @(posedge clk);
         #1;
         src_valid     = ($urandom_range(99) < pv);
         m_axis_tready = ($urandom_range(99) < pr);
         src_data      = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
   endtask

   task automatic doReset(input int n);
      @(posedge clk);
      #1;
      aresetn   = 1'b0;
      src_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      aresetn = 1'b1;
   endtask

   // Monitor and scoreboard, sampled on the falling edge. Beats still pending
   // are taken minus handshaken, so the model stall is simply input absent or
   // that count at the FIFO depth.
   always @(negedge clk) begin
      if (!aresetn) begin
         exp_q.delete();
         beat_idx  = 0;
         hs_count  = 0;
         prev_hold = 1'b0;
      end else begin
         exp_stall = !src_valid || (exp_q.size() >= DEPTH);
         checkOutput("stall", DW'(stall), DW'(exp_stall));

         got_b = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
         if (prev_hold) begin
            checkOutput("hold_tvalid", DW'(m_axis_tvalid), DW'(1'b1));
            checkOutput("hold_tdata", m_axis_tdata, prev_beat.data);
            checkOutput("hold_flags", DW'({m_axis_tlast, m_axis_tuser}),
                        DW'({prev_beat.last, prev_beat.user}));
         end

         if (m_axis_tvalid && m_axis_tready) begin
            checkOutput("beat_expected", DW'(exp_q.size() != 0), DW'(1'b1));
            if (exp_q.size() != 0) begin
               exp_b = exp_q.pop_front();
               checkOutput("tdata", got_b.data, exp_b.data);
               checkOutput("tlast", DW'(got_b.last), DW'(exp_b.last));
               checkOutput("tuser", DW'(got_b.user), DW'(exp_b.user));
            end
            hs_count++;
         end

         if (src_valid && !exp_stall) begin
            exp_q.push_back({src_data, ((beat_idx % BPR) == BPR - 1),
                             ((beat_idx % FRAME) == 0)});
            beat_idx++;
         end

         prev_hold = m_axis_tvalid && !m_axis_tready;
         prev_beat = got_b;
      end
   end

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      $display("[TB] sobel_axis_tx scoreboard bench starting");

      // Reset state
      aresetn       = 1'b0;
      src_valid     = 1'b0;
      m_axis_tready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_tvalid", DW'(m_axis_tvalid), DW'(1'b0));
      checkOutput("reset_tlast", DW'(m_axis_tlast), DW'(1'b0));
      checkOutput("reset_tuser", DW'(m_axis_tuser), DW'(1'b0));
      checkOutput("reset_stall", DW'(stall), DW'(1'b1));

      // First-beat latency: take in cycle 0, output valid LAT+1 cycles later
      @(posedge clk);
      #1;
      aresetn       = 1'b1;
      src_valid     = 1'b1;
      m_axis_tready = 1'b1;
      src_data      = {$urandom(), $urandom(), $urandom(), $urandom()};
      lat = 0;
      while (lat < 60) begin
         @(posedge clk);
         #1;
         src_data = {$urandom(), $urandom(), $urandom(), $urandom()};
         lat++;
         @(negedge clk);
         if (m_axis_tvalid) break;
      end
      checkOutput("latency", DW'(lat), DW'(LAT + 1));

      // Full-frame streaming, past the frame boundary at beat FRAME
      applyStimulus(320, 100, 100);

      // Long sink backpressure, then release
      applyStimulus(100, 100, 0);
      applyStimulus(150, 100, 100);

      // Random traffic over several frames
      applyStimulus(2000, 70, 50);

      // Reset in the middle of a frame after 37 delivered beats
      doReset(2);
      for (int i = 0; i < 300 && hs_count < 37; i++) begin
         applyStimulus(1, 100, 100);
      end
      checkOutput("beats_before_reset", DW'(hs_count >= 37), DW'(1'b1));
      doReset(2);
      @(negedge clk);
      checkOutput("post_reset_tvalid", DW'(m_axis_tvalid), DW'(1'b0));
      checkOutput("post_reset_tuser", DW'(m_axis_tuser), DW'(1'b0));
      applyStimulus(200, 100, 100);

      // Drain: the input stops, so the filter freezes with LAT beats inside
      applyStimulus(100, 100, 100);
      applyStimulus(40, 0, 100);
      @(negedge clk);
      checkOutput("drain_tvalid", DW'(m_axis_tvalid), DW'(1'b0));
      checkOutput("drain_pending", DW'(exp_q.size()), DW'(LAT));

`ifdef SOBEL_TX_CHECK_EN
      checkOutput("err_ovf", DW'(err_ovf), DW'(1'b0));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
